adc_multich_model: RTL and testbench

Parametrised, clock-synchronous successor to the single-channel S3 ADC behavioural model. It takes NCH pre-quantised sample codes and derives a conversion strobe from CLK by a programmable divider, re-aligned by CLK_ST. It TMR-votes the OM/DF/CAL controls and runs power-down, calibration, latency-drain and run sequencing. It delivers formatted codes with a data strobe, per-channel over-range flags, calibration busy, DF-misuse error and SEU indication to the DTU front end and to benches.

---
 rtl/adc_multich_pkg.sv | 23 ++
 rtl/adc_lat_pipe.sv | 31 +++
 rtl/adc_multich_model.sv | 177 +++++++++++++++++
 tb/tb_adc_multich_model.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_multich_pkg.sv
// Shared types and helpers for the multichannel ADC behavioural model.
package adc_multich_pkg;

    typedef enum logic [2:0] {ST_PD, ST_CAL, ST_DRAIN, ST_RUN, ST_CRST} state_e;

    localparam int DIV_DEF     = 8;
    localparam int CAL_CYC_DEF = 26762;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic vote3(input logic [2:0] t);
        return (t[0] & t[1]) | (t[0] & t[2]) | (t[1] & t[2]);
    endfunction

    // Two's complement from offset binary is a flip of the code MSB.
    function automatic logic [31:0] fmt_code(input logic [31:0] code, input int w, input logic tc);
        return tc ? (code ^ (32'd1 << (w - 1))) : code;
    endfunction

endpackage

// File: rtl/adc_lat_pipe.sv
// Sample latency shift register with advance enable and synchronous clear.
module adc_lat_pipe #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

    always_comb begin
        stage_d = stage_q;
        if (clr) begin
            stage_d = '0;
        end else if (adv) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stage_q <= '0;
        else     stage_q <= stage_d;
    end

    assign dout = stage_q[DEPTH-1];
endmodule

// File: rtl/adc_multich_model.sv
// Multichannel ADC model: strobe divider, TMR-voted control FSM, latency pipe and output formatting.
module adc_multich_model
    import adc_multich_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int W        = 12,
    parameter int LAT      = 12,
    parameter int DIV      = DIV_DEF,
    parameter int CAL_CYC  = CAL_CYC_DEF,
    parameter int SEU_HOLD = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLK_ST,
    input  logic [2:0]       OM,
    input  logic [2:0]       DF,
    input  logic [2:0]       CAL,
    input  logic [NCH*W-1:0] VIN_CODE,
    input  logic             VIN_VALID,
    output logic [NCH*W-1:0] D,
    output logic             DSTB,
    output logic [NCH-1:0]   OVF,
    output logic             CAL_BUSY,
    output logic             DF_ERR,
    output logic             SEU
);
    localparam int DIV_W   = cnt_w(DIV);
    localparam int CAL_W   = cnt_w(CAL_CYC);
    localparam int DRN_W   = cnt_w(LAT);
    localparam int SEU_W   = cnt_w(SEU_HOLD);
    localparam int SEU_LIM = (SEU_HOLD < 1) ? 0 : SEU_HOLD - 1;

    logic om_v, df_v, cal_v, mismatch, stb, run_stb, pipe_adv, pipe_clr;
    logic [NCH*W-1:0] pipe_in, pipe_out;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [CAL_W-1:0] cal_cnt_q, cal_cnt_d;
    logic [DRN_W-1:0] drn_cnt_q, drn_cnt_d;
    logic [SEU_W-1:0] hold_q, hold_d;
    logic [NCH*W-1:0] d_q, d_d;
    logic [NCH-1:0]   ovf_q, ovf_d;
    logic             dstb_q, dstb_d, busy_q, busy_d, df_err_q, df_err_d;
    logic             df_prev_q, df_prev_d, seu_q, seu_d;

    assign om_v     = vote3(OM);
    assign df_v     = vote3(DF);
    assign cal_v    = vote3(CAL);
    assign mismatch = (|OM & ~&OM) | (|DF & ~&DF) | (|CAL & ~&CAL);

    // Alignment suppresses the strobe it collides with.
    assign stb   = (cnt_q == DIV_W'(DIV - 1)) && !CLK_ST;
    assign cnt_d = (CLK_ST || stb) ? '0 : cnt_q + DIV_W'(1);

    always_comb begin
        state_d   = state_q;
        cal_cnt_d = cal_cnt_q;
        drn_cnt_d = drn_cnt_q;
        if (!om_v) begin
            state_d   = ST_PD;
            cal_cnt_d = '0;
            drn_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_PD: begin
                    state_d   = ST_CAL;
                    cal_cnt_d = '0;
                end
                ST_CAL:
                    if (cal_v) state_d = ST_CRST;
                    else if (stb) begin
                        if (cal_cnt_q == CAL_W'(CAL_CYC - 1)) begin
                            state_d   = ST_DRAIN;
                            drn_cnt_d = '0;
                        end else cal_cnt_d = cal_cnt_q + CAL_W'(1);
                    end
                ST_DRAIN:
                    if (cal_v) state_d = ST_CRST;
                    else if (stb) begin
                        if (drn_cnt_q == DRN_W'(LAT - 1)) state_d = ST_RUN;
                        else drn_cnt_d = drn_cnt_q + DRN_W'(1);
                    end
                ST_RUN:
                    if (cal_v) state_d = ST_CRST;
                ST_CRST:
                    if (!cal_v) begin
                        state_d   = ST_CAL;
                        cal_cnt_d = '0;
                    end
                default: state_d = ST_PD;
            endcase
        end
    end

    assign pipe_adv = stb && (state_q == ST_DRAIN || state_q == ST_RUN);
    assign pipe_clr = (state_d == ST_PD) || (state_d == ST_CRST);
    assign pipe_in  = VIN_VALID ? VIN_CODE : '0;
    assign run_stb  = stb && (state_q == ST_RUN) && (state_d == ST_RUN);

    adc_lat_pipe #(.WIDTH(NCH*W), .DEPTH(LAT-1)) u_pipe (
        .clk(CLK), .rst(RST), .adv(pipe_adv), .clr(pipe_clr), .din(pipe_in), .dout(pipe_out)
    );

    always_comb begin
        logic [W-1:0] raw;
        raw       = '0;
        df_prev_d = df_v;
        busy_d    = (state_d == ST_CAL) || (state_d == ST_DRAIN);
        dstb_d    = run_stb;
        // Entering power-down clears the error even if DF moved this same cycle.
        df_err_d  = df_err_q;
        if (df_v != df_prev_q && state_q != ST_PD) df_err_d = 1'b1;
        if (state_d == ST_PD) df_err_d = 1'b0;

        d_d   = d_q;
        ovf_d = ovf_q;
        if (state_d != ST_RUN || df_err_d) begin
            d_d   = '0;
            ovf_d = '0;
        end else if (run_stb) begin
            for (int ch = 0; ch < NCH; ch++) begin
                raw              = pipe_out[ch*W +: W];
                d_d[ch*W +: W]   = W'(fmt_code(32'(raw), W, df_v));
                ovf_d[ch]        = (raw == '0) || (raw == '1);
            end
        end

        seu_d  = seu_q;
        hold_d = hold_q;
        if (mismatch) begin
            seu_d  = 1'b1;
            hold_d = '0;
        end else if (seu_q && stb) begin
            if (hold_q == SEU_W'(SEU_LIM)) begin
                seu_d  = 1'b0;
                hold_d = '0;
            end else hold_d = hold_q + SEU_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_PD;
            cnt_q     <= '0;
            cal_cnt_q <= '0;
            drn_cnt_q <= '0;
            hold_q    <= '0;
            d_q       <= '0;
            ovf_q     <= '0;
            dstb_q    <= 1'b0;
            busy_q    <= 1'b0;
            df_err_q  <= 1'b0;
            df_prev_q <= 1'b0;
            seu_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cal_cnt_q <= cal_cnt_d;
            drn_cnt_q <= drn_cnt_d;
            hold_q    <= hold_d;
            d_q       <= d_d;
            ovf_q     <= ovf_d;
            dstb_q    <= dstb_d;
            busy_q    <= busy_d;
            df_err_q  <= df_err_d;
            df_prev_q <= df_prev_d;
            seu_q     <= seu_d;
        end
    end

    assign D        = d_q;
    assign OVF      = ovf_q;
    assign DSTB     = dstb_q;
    assign CAL_BUSY = busy_q;
    assign DF_ERR   = df_err_q;
    assign SEU      = seu_q;
endmodule

// File: tb/tb_adc_multich_model.sv
// Randomized bench for adc_multich_model against a stb-count / queue reference model.
module tb_adc_multich_model;
    localparam int NCH = 2, W = 12, LAT = 4, DIV = 8, CAL_CYC = 16, SEU_HOLD = 4;
    localparam int BUSY_STB = CAL_CYC + LAT;

    logic             CLK = 1'b0;
    logic             RST, CLK_ST, VIN_VALID;
    logic [2:0]       OM, DF, CAL;
    logic [NCH*W-1:0] VIN_CODE, D;
    logic [NCH-1:0]   OVF;
    logic             DSTB, CAL_BUSY, DF_ERR, SEU;

    int checks = 0, errors = 0;
    int ph, n;
    bit stb, tc;
    logic [NCH*W-1:0] hist[$];
    logic [NCH*W-1:0] exp_d;
    logic [NCH-1:0]   exp_ovf;

    adc_multich_model #(.NCH(NCH), .W(W), .LAT(LAT), .DIV(DIV), .CAL_CYC(CAL_CYC), .SEU_HOLD(SEU_HOLD)) dut (
        .CLK(CLK), .RST(RST), .CLK_ST(CLK_ST), .OM(OM), .DF(DF), .CAL(CAL),
        .VIN_CODE(VIN_CODE), .VIN_VALID(VIN_VALID), .D(D), .DSTB(DSTB), .OVF(OVF),
        .CAL_BUSY(CAL_BUSY), .DF_ERR(DF_ERR), .SEU(SEU)
    );

    always #5 CLK = ~CLK;

    function automatic logic [NCH*W-1:0] model_d(input logic [NCH*W-1:0] raw, input bit two_c);
        logic [NCH*W-1:0] r;
        int c;
        r = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            c = int'(raw[ch*W +: W]);
            if (two_c) c = (c + (1 << (W - 1))) % (1 << W);
            r[ch*W +: W] = c[W-1:0];
        end
        return r;
    endfunction

    function automatic logic [NCH-1:0] model_ovf(input logic [NCH*W-1:0] raw);
        logic [NCH-1:0] r;
        int c;
        for (int ch = 0; ch < NCH; ch++) begin
            c = int'(raw[ch*W +: W]);
            r[ch] = (c == 0) || (c == (1 << W) - 1);
        end
        return r;
    endfunction

    task automatic rand_in();
        logic [W-1:0] c;
        for (int ch = 0; ch < NCH; ch++) begin
            case ($urandom_range(0, 4))
                0:       c = '0;
                1:       c = '1;
                2:       c = W'(12'h123);
                default: c = W'($urandom);
            endcase
            VIN_CODE[ch*W +: W] = c;
        end
        VIN_VALID = ($urandom_range(0, 7) != 0);
    endtask

    // Advance one CLK; strobe timing follows "every DIV cycles from the last alignment".
    task automatic step();
        stb = (ph == DIV - 1) && !CLK_ST;
        ph  = CLK_ST ? 0 : (ph + 1) % DIV;
        if (stb) begin
            hist.push_back(VIN_VALID ? VIN_CODE : '0);
            n++;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; OM = '0; DF = '0; CAL = '0; CLK_ST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        ph = 0; n = 0; stb = 0;
        hist.delete();
        exp_d = '0; exp_ovf = '0;
    endtask

    task automatic test_reset();
        RST = 1'b1; OM = 3'b111; DF = 3'b111; CAL = '0; CLK_ST = 1'b0;
        rand_in();
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (D !== '0)        begin errors++; $display("FAIL reset_d got %h exp 0", D); end
        checks++; if (OVF !== '0)      begin errors++; $display("FAIL reset_ovf got %b exp 0", OVF); end
        checks++; if (DSTB !== 1'b0)   begin errors++; $display("FAIL reset_dstb got %b exp 0", DSTB); end
        checks++; if (CAL_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", CAL_BUSY); end
        checks++; if (DF_ERR !== 1'b0) begin errors++; $display("FAIL reset_dferr got %b exp 0", DF_ERR); end
        checks++; if (SEU !== 1'b0)    begin errors++; $display("FAIL reset_seu got %b exp 0", SEU); end
    endtask

    // n counts strobes since entering CAL; checks busy window, first DSTB and LAT-1 strobe latency.
    task automatic test_stream(input int upto);
        int  g;
        bit  e_busy, e_dstb;
        g = 0;
        while (n < upto && g < 3000) begin
            rand_in();
            step();
            g++;
            e_busy = (n < BUSY_STB);
            e_dstb = stb && (n > BUSY_STB);
            if (e_dstb) begin
                exp_d   = model_d(hist[n-LAT], tc);
                exp_ovf = model_ovf(hist[n-LAT]);
            end
            checks++; if (CAL_BUSY !== e_busy) begin errors++; $display("FAIL stream_busy n=%0d got %b exp %b", n, CAL_BUSY, e_busy); end
            checks++; if (DSTB !== e_dstb)     begin errors++; $display("FAIL stream_dstb n=%0d got %b exp %b", n, DSTB, e_dstb); end
            checks++; if (D !== exp_d)         begin errors++; $display("FAIL stream_d n=%0d got %h exp %h", n, D, exp_d); end
            checks++; if (OVF !== exp_ovf)     begin errors++; $display("FAIL stream_ovf n=%0d got %b exp %b", n, OVF, exp_ovf); end
        end
        checks++; if (n < upto) begin errors++; $display("FAIL stream_timeout got %0d stb exp %0d", n, upto); end
    endtask

    task automatic test_startup(input bit two_c, input int upto);
        do_reset();
        tc = two_c;
        OM = 3'b111; DF = two_c ? 3'b111 : 3'b000; CAL = 3'b000;
        test_stream(upto);
    endtask

    task automatic test_df_err();
        test_startup(1, 26);
        DF = 3'b000;
        step();
        checks++; if (DF_ERR !== 1'b1)   begin errors++; $display("FAIL dferr_set got %b exp 1", DF_ERR); end
        checks++; if (CAL_BUSY !== 1'b0) begin errors++; $display("FAIL dferr_busy got %b exp 0", CAL_BUSY); end
        repeat (20) begin
            rand_in();
            step();
            checks++; if (D !== '0 || OVF !== '0) begin errors++; $display("FAIL dferr_mask got %h/%b exp 0/0", D, OVF); end
            checks++; if (DF_ERR !== 1'b1) begin errors++; $display("FAIL dferr_sticky got %b exp 1", DF_ERR); end
        end
        OM = 3'b000;
        step();
        checks++; if (DF_ERR !== 1'b0)   begin errors++; $display("FAIL dferr_clear got %b exp 0", DF_ERR); end
        checks++; if (CAL_BUSY !== 1'b0 || D !== '0) begin errors++; $display("FAIL pd_out got %b/%h exp 0/0", CAL_BUSY, D); end
        DF = 3'b111;
        step();
        checks++; if (DF_ERR !== 1'b0)   begin errors++; $display("FAIL dferr_pd got %b exp 0", DF_ERR); end
    endtask

    task automatic test_cal_hold();
        test_startup(0, 24);
        CAL = 3'b111;
        repeat (10) begin
            rand_in();
            step();
            checks++; if (CAL_BUSY !== 1'b0) begin errors++; $display("FAIL crst_busy got %b exp 0", CAL_BUSY); end
            checks++; if (D !== '0 || OVF !== '0) begin errors++; $display("FAIL crst_out got %h/%b exp 0/0", D, OVF); end
        end
        CAL = 3'b000;
        step();
        checks++; if (CAL_BUSY !== 1'b1) begin errors++; $display("FAIL recal_busy got %b exp 1", CAL_BUSY); end
        n = 0; hist.delete(); exp_d = '0; exp_ovf = '0;
        test_stream(26);
    endtask

    task automatic test_seu();
        int k, g;
        test_startup(0, 24);
        OM = 3'b011;
        repeat (3) begin
            step();
            checks++; if (SEU !== 1'b1)      begin errors++; $display("FAIL seu_set got %b exp 1", SEU); end
            checks++; if (CAL_BUSY !== 1'b0) begin errors++; $display("FAIL seu_om_vote got %b exp 0", CAL_BUSY); end
        end
        OM = 3'b111; k = 0; g = 0;
        while (k < SEU_HOLD && g < 200) begin
            step(); g++;
            if (stb) k++;
            checks++; if (SEU !== (k < SEU_HOLD)) begin errors++; $display("FAIL seu_hold k=%0d got %b exp %b", k, SEU, k < SEU_HOLD); end
            checks++; if (DSTB !== stb) begin errors++; $display("FAIL seu_run_dstb got %b exp %b", DSTB, stb); end
        end
        checks++; if (k < SEU_HOLD) begin errors++; $display("FAIL seu_timeout got %0d exp %0d", k, SEU_HOLD); end
        CAL = 3'b100;
        step();
        checks++; if (SEU !== 1'b1) begin errors++; $display("FAIL seu_reset got %b exp 1", SEU); end
        CAL = 3'b000; k = 0; g = 0;
        while (k < 2 && g < 100) begin
            step(); g++;
            if (stb) k++;
            checks++; if (SEU !== 1'b1) begin errors++; $display("FAIL seu_partial got %b exp 1", SEU); end
        end
        DF = 3'b010;
        step();
        DF = 3'b000; k = 0; g = 0;
        while (k < SEU_HOLD && g < 200) begin
            step(); g++;
            if (stb) k++;
            checks++; if (SEU !== (k < SEU_HOLD)) begin errors++; $display("FAIL seu_restart k=%0d got %b exp %b", k, SEU, k < SEU_HOLD); end
        end
        checks++; if (DF_ERR !== 1'b0) begin errors++; $display("FAIL seu_dferr got %b exp 0", DF_ERR); end
    endtask

    task automatic test_clk_st();
        test_startup(0, 24);
        for (int g = 0; g < 2 * DIV && ph != 3; g++) step();
        CLK_ST = 1'b1;
        step();
        CLK_ST = 1'b0;
        checks++; if (DSTB !== 1'b0) begin errors++; $display("FAIL clkst_pulse got %b exp 0", DSTB); end
        for (int i = 1; i <= DIV; i++) begin
            step();
            checks++; if (DSTB !== (i == DIV)) begin errors++; $display("FAIL clkst_align i=%0d got %b exp %b", i, DSTB, i == DIV); end
        end
        for (int g = 0; g < 2 * DIV && ph != DIV - 1; g++) step();
        CLK_ST = 1'b1;
        step();
        CLK_ST = 1'b0;
        checks++; if (DSTB !== 1'b0) begin errors++; $display("FAIL clkst_collide got %b exp 0", DSTB); end
        for (int i = 1; i <= DIV; i++) begin
            step();
            checks++; if (DSTB !== (i == DIV)) begin errors++; $display("FAIL clkst_realign i=%0d got %b exp %b", i, DSTB, i == DIV); end
        end
    endtask

    task automatic test_rst_mid_run();
        test_startup(1, 24);
        RST = 1'b1;
        #1;
        checks++; if (D !== '0 || OVF !== '0 || DSTB !== 1'b0)
            begin errors++; $display("FAIL rst_async_data got %h/%b/%b exp 0/0/0", D, OVF, DSTB); end
        checks++; if (CAL_BUSY !== 1'b0 || DF_ERR !== 1'b0 || SEU !== 1'b0)
            begin errors++; $display("FAIL rst_async_flags got %b/%b/%b exp 0/0/0", CAL_BUSY, DF_ERR, SEU); end
    endtask

    initial begin
        RST = 1'b1; CLK_ST = 1'b0; OM = '0; DF = '0; CAL = '0; VIN_CODE = '0; VIN_VALID = 1'b0;
        test_reset();
        test_startup(0, 32);
        test_startup(1, 32);
        test_df_err();
        test_cal_hold();
        test_seu();
        test_clk_st();
        test_rst_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
